enc8_arb: RTL and testbench
===========================

// Module: enc8_arb
// PURPOSE
// - Sequential 8-to-3 arbitrating encoder; performs the inverse function of the 3-to-8 select decoder.
// - Samples eight request lines, picks one winner and registers its 3-bit index.
// - Holds the index until the consumer accepts it with a valid/ready handshake.
// - Sits upstream of the decoder: sel_out feeds its sel, valid feeds its en.
// PARAMETERS
// - CNT_W     8  width of the accepted-grant counter gnt_cnt.
// - RST_PTR   0  round-robin pointer value after reset; legal range 0..7.
// PORTS
// - clk      in   1      system clock; all state updates on the rising edge.
// - rst      in   1      asynchronous, active-high reset.
// - en       in   1      arbitration enable; gates loading of a new grant only.
// - req      in   8      level request lines; bit i requests index i.
// - ready    in   1      consumer accepts the current sel_out.
// - sel_out  out  3      encoded winner index, registered.
// - grant    out  8      one-hot copy of sel_out; all zeros when valid is 0.
// - valid    out  1      sel_out/grant hold a grant that has not been accepted.
// - gnt_cnt  out  CNT_W  number of accepted grants (valid & ready), wrapping.
// BEHAVIOUR
// - Reset: sel_out=0, grant=0, valid=0, gnt_cnt=0, ptr=RST_PTR, FSM=IDLE.
//   - Reset takes effect immediately, mid-grant included.
//   - No pending grant survives reset.
// - FSM has two states: IDLE (valid=0) and HOLD (valid=1).
// - Load event: en & |req, evaluated in IDLE, or in HOLD on the handshake cycle.
// - IDLE:
//   - Load event -> next edge registers the winner index and goes to HOLD.
//   - Latency is 1 cycle from the sampled request to valid=1.
//   - No load event -> stay in IDLE with outputs unchanged.
// - HOLD:
//   - sel_out/grant stay stable while ready=0, even if req changes or en falls.
//   - A grant is never retracted.
//   - Handshake (valid & ready):
//     - gnt_cnt increments; it wraps at 2^CNT_W-1 -> 0.
//     - ptr <= (winner+1) mod 8.
//     - If a load event occurs in the same cycle, the next winner is registered and the FSM stays in HOLD.
//       This gives back-to-back grants with no bubble. Priority uses the updated ptr.
//     - Otherwise go to IDLE and drop valid.
// - ready while in IDLE is ignored; the counter does not move.
// - Winner search starts at index ptr and proceeds ptr, ptr+1, ..., 7, 0, ..., ptr-1.
//   - The first set req bit wins.
//   - Wrap-around from 7 to 0 is required.
// - A requester that is still asserted after being served drops to lowest priority.
// - req is sampled only on load-event cycles; pulses outside those cycles are not remembered.
// - grant == (valid ? 8'b1 << sel_out : 8'b0) at all times, registered with no combinational path from req.
// CONFIGURATION
// - ENC8_RR_EN defined:
//   - Round-robin behaviour as above; ptr rotates after every handshake.
// - ENC8_RR_EN undefined:
//   - Fixed priority; the lowest set index always wins.
//   - The pointer register and RST_PTR are unused and ptr is held at 0.
//   - All handshake, counter and latency rules are unchanged.
// TESTING
// - Reset: assert rst mid-HOLD with sel_out=5.
//   -> Same cycle: valid=0, grant=0, gnt_cnt=0.
//   -> After release with req=0: stays IDLE.
// - Single request: req=8'h10, en=1, ready=1 from IDLE.
//   -> 1 cycle later: sel_out=4, grant=8'h10, valid=1.
//   -> Next edge: gnt_cnt=1.
// - Backpressure: req=8'h81, ready=0 for 5 cycles, req changed to 8'h02 meanwhile.
//   -> sel_out stays 0 and valid stays 1 throughout.
// - Round-robin (ENC8_RR_EN): req=8'hFF held, ready=1.
//   -> Grant sequence 0,1,...,7,0 on consecutive cycles, no bubbles.
//   -> Repeat without the macro -> 0,0,0,...
// - Wrap: ptr=6 after serving 5, req=8'h03.
//   -> Winner 0, then 1.
//   -> Drive 2^CNT_W handshakes -> gnt_cnt returns to 0.
// - en low: en=0 with req=8'h04 in IDLE -> valid stays 0; raise en -> sel_out=2 next cycle.

Source files
------------

// File: rtl/enc8_arb.sv
// -----------------------------------------------------------------------------
// enc8_arb -- sequential 8-to-3 arbitrating encoder.
//
// This block samples eight request lines and picks one winner. It registers
// the winner's 3-bit index and holds it until a valid/ready handshake accepts
// it. It drives the 3-to-8 select decoder: sel_out feeds sel and valid feeds en.
//
// Configuration macro ENC8_RR_EN:
//   defined   : round-robin priority. The search pointer moves to winner+1
//               after every handshake.
//   undefined : fixed priority. The lowest set index always wins and the
//               pointer is tied to 0.
//
// Parameters:
//   CNT_W    width of the accepted-grant counter
//   RST_PTR  round-robin pointer value after reset (0..7)
//
// Ports:
//   clk      in   1      system clock, rising edge
//   rst      in   1      asynchronous active-high reset
//   en       in   1      arbitration enable; gates loading of a new grant only
//   req      in   8      level request lines, bit i requests index i
//   ready    in   1      consumer accepts current sel_out
//   sel_out  out  3      registered winner index
//   grant    out  8      one-hot copy of sel_out, zero when valid is low
//   valid    out  1      an unaccepted grant is being held
//   gnt_cnt  out  CNT_W  number of accepted grants, wrapping
// -----------------------------------------------------------------------------
module enc8_arb #(
    parameter int CNT_W   = 8,
    parameter int RST_PTR = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [7:0]       req,
    input  logic             ready,
    output logic [2:0]       sel_out,
    output logic [7:0]       grant,
    output logic             valid,
    output logic [CNT_W-1:0] gnt_cnt
);

    if (RST_PTR < 0 || RST_PTR > 7) begin : g_bad_ptr
        $error("enc8_arb: RST_PTR must be in 0..7");
    end

    typedef enum logic {IDLE, HOLD} state_t;

    state_t           state_q;
    logic [2:0]       sel_q;
    logic [7:0]       grant_q;
    logic             valid_q;
    logic [CNT_W-1:0] cnt_q;

    logic       hs;
    logic       load;
    logic [2:0] ptr_d;
    logic [2:0] winner;

    // This function scans from index p upward and wraps from 7 to 0. It
    // returns the first set request bit it finds.
    function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] idx;
        logic       found;
        pick  = p;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = p + 3'(i);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

    assign hs   = valid_q & ready;
    // A new grant can load from IDLE, or in HOLD on the cycle the current
    // grant is accepted. That second case gives back-to-back grants.
    assign load = en & (|req) & (~valid_q | hs);

`ifdef ENC8_RR_EN
    logic [2:0] ptr_q;
    // The pointer advances on the handshake cycle itself. A grant loaded in
    // that same cycle therefore already sees the served requester at lowest
    // priority.
    assign ptr_d = hs ? sel_q + 3'd1 : ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= 3'(RST_PTR);
        else     ptr_q <= ptr_d;
    end
`else
    assign ptr_d = 3'd0;
`endif

    assign winner = pick(req, ptr_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            grant_q <= 8'd0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (hs) cnt_q <= cnt_q + CNT_W'(1);
            case (state_q)
                IDLE: begin
                    if (load) begin
                        sel_q   <= winner;
                        grant_q <= 8'd1 << winner;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (hs) begin
                        if (load) begin
                            sel_q   <= winner;
                            grant_q <= 8'd1 << winner;
                        end else begin
                            grant_q <= 8'd0;
                            valid_q <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sel_out = sel_q;
    assign grant   = grant_q;
    assign valid   = valid_q;
    assign gnt_cnt = cnt_q;

endmodule

// File: tb/tb_enc8_arb.sv
// -----------------------------------------------------------------------------
// tb_enc8_arb -- self-checking bench for enc8_arb.
// A table of per-cycle vectors exercises backpressure, the en gate, an idle
// ready and back-to-back grants. Hand-written sequences cover round-robin
// order, pointer wrap, counter wrap and asynchronous reset during HOLD.
// Expected outputs go into a queue when a cycle is driven. They are popped
// and compared after that cycle's rising edge.
// -----------------------------------------------------------------------------
module tb_enc8_arb;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic [7:0]       req = 8'd0;
    logic             ready = 1'b0;
    logic [2:0]       sel_out;
    logic [7:0]       grant;
    logic             valid;
    logic [CNT_W-1:0] gnt_cnt;

    enc8_arb #(.CNT_W(CNT_W), .RST_PTR(0)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .ready(ready),
        .sel_out(sel_out), .grant(grant), .valid(valid), .gnt_cnt(gnt_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       sel;
        logic [7:0]       gnt;
        logic             vld;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    typedef struct {
        logic       en;
        logic [7:0] req;
        logic       rdy;
        exp_t       e;
    } vec_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(input logic [2:0] s, input logic v, input int c);
        exp_t r;
        r.sel = s;
        r.vld = v;
        r.gnt = v ? (8'd1 << s) : 8'd0;
        r.cnt = CNT_W'(c);
        return r;
    endfunction

    task automatic compare(input string name, input exp_t e);
        checks++;
        if (sel_out !== e.sel || grant !== e.gnt || valid !== e.vld || gnt_cnt !== e.cnt) begin
            errors++;
            $display("FAIL %s: got sel=%0d grant=%h valid=%b cnt=%0d, want sel=%0d grant=%h valid=%b cnt=%0d",
                     name, sel_out, grant, valid, gnt_cnt, e.sel, e.gnt, e.vld, e.cnt);
        end
    endtask

    // This task drives one cycle and queues what the outputs must be after
    // the next rising edge. It then samples 1 time unit past that edge.
    task automatic step(input string name, input logic e_i, input logic [7:0] r_i,
                        input logic rd_i, input exp_t e);
        exp_t got;
        en = e_i; req = r_i; ready = rd_i;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        compare(name, got);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; en = 1'b0; req = 8'd0; ready = 1'b0;
        #1;
        compare("reset", mk(3'd0, 1'b0, 0));
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    vec_t tbl[14];

    initial begin
        logic [2:0] w;
        logic [2:0] w1;
        logic [2:0] w2;

        // The pointer is 0 after reset. Every winner below is the same under
        // fixed priority and under round-robin.
        tbl[0]  = '{1'b1, 8'h81, 1'b0, mk(3'd0, 1'b1, 0)};   // load, stall
        tbl[1]  = '{1'b1, 8'h02, 1'b0, mk(3'd0, 1'b1, 0)};   // req changes, held
        tbl[2]  = '{1'b0, 8'h02, 1'b0, mk(3'd0, 1'b1, 0)};   // en falls, held
        tbl[3]  = '{1'b1, 8'h81, 1'b0, mk(3'd0, 1'b1, 0)};
        tbl[4]  = '{1'b1, 8'h02, 1'b0, mk(3'd0, 1'b1, 0)};   // 5 stall cycles
        tbl[5]  = '{1'b1, 8'h00, 1'b1, mk(3'd0, 1'b0, 1)};   // accept, go idle
        tbl[6]  = '{1'b1, 8'h00, 1'b1, mk(3'd0, 1'b0, 1)};   // ready in idle ignored
        tbl[7]  = '{1'b1, 8'h10, 1'b1, mk(3'd4, 1'b1, 1)};   // single request
        tbl[8]  = '{1'b0, 8'h00, 1'b1, mk(3'd4, 1'b0, 2)};   // accepted
        tbl[9]  = '{1'b0, 8'h04, 1'b0, mk(3'd4, 1'b0, 2)};   // en low blocks load
        tbl[10] = '{1'b0, 8'h04, 1'b1, mk(3'd4, 1'b0, 2)};
        tbl[11] = '{1'b1, 8'h04, 1'b0, mk(3'd2, 1'b1, 2)};   // en high -> sel 2
        tbl[12] = '{1'b1, 8'h04, 1'b1, mk(3'd2, 1'b1, 3)};   // accept + reload
        tbl[13] = '{1'b1, 8'h00, 1'b1, mk(3'd2, 1'b0, 4)};

        // Check the state while reset is held from time 0.
        #2;
        compare("reset_init", mk(3'd0, 1'b0, 0));
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 14; i++)
            step($sformatf("tbl%0d", i), tbl[i].en, tbl[i].req, tbl[i].rdy, tbl[i].e);

        // Round-robin sweep with all requests held high. This gives one grant
        // per cycle with no bubbles.
        do_reset();
        for (int k = 0; k < 9; k++) begin
`ifdef ENC8_RR_EN
            w = 3'(k % 8);
`else
            w = 3'd0;
`endif
            step($sformatf("rr%0d", k), 1'b1, 8'hFF, 1'b1, mk(w, 1'b1, k));
        end
        step("rr_drain", 1'b1, 8'h00, 1'b1, mk(w, 1'b0, 9));

        // Assert reset asynchronously in mid-HOLD with sel_out=5.
        step("pre_rst", 1'b1, 8'h20, 1'b0, mk(3'd5, 1'b1, 9));
        step("pre_rst_hold", 1'b1, 8'h20, 1'b0, mk(3'd5, 1'b1, 9));
        #2;
        rst = 1'b1;
        #1;
        compare("async_rst", mk(3'd0, 1'b0, 0));
        @(posedge clk); #1;
        rst = 1'b0;
        step("post_rst0", 1'b1, 8'h00, 1'b1, mk(3'd0, 1'b0, 0));
        step("post_rst1", 1'b1, 8'h00, 1'b1, mk(3'd0, 1'b0, 0));

        // Pointer wrap: serving 5 moves the pointer to 6, then req=03.
`ifdef ENC8_RR_EN
        w1 = 3'd0; w2 = 3'd1;
`else
        w1 = 3'd0; w2 = 3'd0;
`endif
        step("wrap_load5", 1'b1, 8'h20, 1'b1, mk(3'd5, 1'b1, 0));
        step("wrap_w1", 1'b1, 8'h03, 1'b1, mk(w1, 1'b1, 1));
        step("wrap_w2", 1'b1, 8'h03, 1'b1, mk(w2, 1'b1, 2));

        // Counter wrap: 2^CNT_W handshakes bring gnt_cnt back to its start.
        do_reset();
        step("cw_load", 1'b1, 8'h01, 1'b1, mk(3'd0, 1'b1, 0));
        for (int k = 1; k <= (1 << CNT_W); k++) begin
            en = 1'b1; req = 8'h01; ready = 1'b1;
            sb_q.push_back(mk(3'd0, 1'b1, k % (1 << CNT_W)));
            @(posedge clk); #1;
            begin
                exp_t e;
                e = sb_q.pop_front();
                if (k == (1 << CNT_W) - 1 || k == (1 << CNT_W)) compare($sformatf("cnt_wrap%0d", k), e);
                else if (gnt_cnt !== e.cnt) begin
                    checks++;
                    errors++;
                    $display("FAIL cnt_step%0d: got %0d want %0d", k, gnt_cnt, e.cnt);
                end else checks++;
            end
        end

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
